// File: rtl/key_debounce_pkg.sv
// Shared definitions for the touch-key conditioning block: arbiter state
// encoding and default debounce timing for a 25 MHz clock.
package key_pkg;

    localparam logic [2:0] KEY_ST_IDLE  = 3'd0;
    localparam logic [2:0] KEY_ST_UP    = 3'd1;
    localparam logic [2:0] KEY_ST_DOWN  = 3'd2;
    localparam logic [2:0] KEY_ST_LEFT  = 3'd3;
    localparam logic [2:0] KEY_ST_RIGHT = 3'd4;

    // 20 ms at 25 MHz, and the narrowest counter that can reach it
    localparam int KEY_DEBOUNCE_CYCLES = 500000;
    localparam int KEY_CNT_W           = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = KEY_ST_IDLE,
        ST_UP    = KEY_ST_UP,
        ST_DOWN  = KEY_ST_DOWN,
        ST_LEFT  = KEY_ST_LEFT,
        ST_RIGHT = KEY_ST_RIGHT
    } key_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of the four raw pad inputs and the conditioned direction levels.
// The pad side drives the raw levels, the debouncer drives the clean ones.
interface key_debounce_if;

    logic KEY_up_raw;
    logic KEY_down_raw;
    logic KEY_left_raw;
    logic KEY_right_raw;
    logic KEY_up;
    logic KEY_down;
    logic KEY_left;
    logic KEY_right;
    logic KEY_busy;

    modport master (
        output KEY_up_raw, KEY_down_raw, KEY_left_raw, KEY_right_raw,
        input  KEY_up, KEY_down, KEY_left, KEY_right, KEY_busy
    );

    modport slave (
        input  KEY_up_raw, KEY_down_raw, KEY_left_raw, KEY_right_raw,
        output KEY_up, KEY_down, KEY_left, KEY_right, KEY_busy
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, stability counter that flips the
// clean level only after DEBOUNCE_CYCLES consecutive mismatching samples,
// and a one-cycle rise flag for the arbiter.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int CNT_W           = KEY_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then count consecutive disagreements; any agreeing sample restarts the window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            prev <= clean;
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = clean & ~prev;

endmodule

// File: rtl/key_debounce.sv
// Four debounced touch keys feeding a single-winner arbiter. Only a fresh
// debounced press can claim the outputs, and the winner keeps them until its
// own key is released; everything else in the meantime is ignored.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int CNT_W           = KEY_CNT_W
) (
    input  logic           KEY_clk,
    input  logic           KEY_rst_n,
    key_debounce_if.slave  keys
);

    // Bit order everywhere below: 0 = up, 1 = down, 2 = left, 3 = right
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] dir_q;
    logic       busy_q;
    key_state_e state;
    key_state_e next_state;

    assign raw = {keys.KEY_right_raw, keys.KEY_left_raw, keys.KEY_down_raw, keys.KEY_up_raw};

    for (genvar i = 0; i < 4; i++) begin : gen_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (KEY_clk),
            .rst_n (KEY_rst_n),
            .raw   (raw[i]),
            .clean (clean[i]),
            .rise  (rise[i])
        );
    end

    // Pick the next holder: fixed priority among fresh rises, or release when the holder's key drops
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (rise[0])      next_state = ST_UP;
                else if (rise[1]) next_state = ST_DOWN;
                else if (rise[2]) next_state = ST_LEFT;
                else if (rise[3]) next_state = ST_RIGHT;
            end
            ST_UP:    if (!clean[0]) next_state = ST_IDLE;
            ST_DOWN:  if (!clean[1]) next_state = ST_IDLE;
            ST_LEFT:  if (!clean[2]) next_state = ST_IDLE;
            ST_RIGHT: if (!clean[3]) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Register the state together with its output decode so outputs change on the same edge as the state
    always_ff @(posedge KEY_clk) begin
        if (!KEY_rst_n) begin
            state  <= ST_IDLE;
            dir_q  <= 4'b0000;
            busy_q <= 1'b0;
        end else begin
            state  <= next_state;
            dir_q  <= {next_state == ST_RIGHT, next_state == ST_LEFT,
                       next_state == ST_DOWN,  next_state == ST_UP};
            busy_q <= (next_state != ST_IDLE);
        end
    end

    assign keys.KEY_up    = dir_q[0];
    assign keys.KEY_down  = dir_q[1];
    assign keys.KEY_left  = dir_q[2];
    assign keys.KEY_right = dir_q[3];
    assign keys.KEY_busy  = busy_q;

endmodule
